// File: rtl/lc3_decode.sv
// LC3 decode stage: registers each accepted instruction, derives its control fields,
// and stalls issue on RAW/WAW hazards tracked by a pending-write scoreboard.
module lc3_decode #(
    parameter int NREG = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_decode,
    input  logic [15:0] instr_in,
    input  logic [15:0] npc_in,
    input  logic        wb_valid,
    input  logic [2:0]  wb_dr,
    output logic [15:0] ir,
    output logic [15:0] npc_out,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [2:0]  W_Control,
    output logic [1:0]  alu_op,
    output logic        imm_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        wb_en,
    output logic        valid_out,
    output logic        stall
);

    logic [15:0]     ir_q, ir_d, npc_q, npc_d;
    logic [2:0]      dr_q, dr_d, sr1_q, sr1_d, sr2_q, sr2_d, wctl_q, wctl_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic            imm_sel_q, imm_sel_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic            wb_en_q, wb_en_d, valid_q, valid_d;
    logic [NREG-1:0] pending_q, pending_d, eff;

    logic [3:0] op;
    logic       is_add, is_and, is_not, is_ld, is_ldr, is_ldi, is_lea;
    logic       is_st, is_str, is_sti, is_jmp;
    logic       f_wb, f_load, f_store;
    logic       use_sr1, use_sr2, use_dst_src;
    logic [2:0] f_dr, f_sr1, f_sr2, f_wctl;
    logic [1:0] f_alu_op;
    logic       hazard, issue;

    always_comb begin
        op     = instr_in[15:12];
        is_add = (op == 4'b0001);
        is_and = (op == 4'b0101);
        is_not = (op == 4'b1001);
        is_ld  = (op == 4'b0010);
        is_ldr = (op == 4'b0110);
        is_ldi = (op == 4'b1010);
        is_lea = (op == 4'b1110);
        is_st  = (op == 4'b0011);
        is_str = (op == 4'b0111);
        is_sti = (op == 4'b1011);
        is_jmp = (op == 4'b1100);

        f_load  = is_ld | is_ldr | is_ldi;
        f_store = is_st | is_str | is_sti;
        f_wb    = is_add | is_and | is_not | f_load | is_lea;

        f_dr  = instr_in[11:9];
        f_sr1 = instr_in[8:6];
        f_sr2 = f_store ? instr_in[11:9] : instr_in[2:0];

        f_wctl = 3'd0;
        if (f_load)      f_wctl = 3'd1;
        else if (is_lea) f_wctl = 3'd2;

        f_alu_op = 2'b11;
        if (is_add)      f_alu_op = 2'b00;
        else if (is_and) f_alu_op = 2'b01;
        else if (is_not) f_alu_op = 2'b10;

        use_sr1     = is_add | is_and | is_not | is_ldr | is_jmp | is_str;
        use_sr2     = (is_add | is_and) & ~instr_in[5];
        use_dst_src = f_store;
    end

    // A retire this cycle is visible to the hazard check (same-cycle bypass).
    always_comb begin
        eff = pending_q;
        if (wb_valid) eff[wb_dr] = 1'b0;

        hazard = (use_sr1 & eff[f_sr1])
               | (use_sr2 & eff[instr_in[2:0]])
               | (use_dst_src & eff[instr_in[11:9]])
               | (f_wb & eff[f_dr]);
        stall  = enable_decode & hazard;
        issue  = enable_decode & ~hazard;
    end

    always_comb begin
        ir_d      = ir_q;
        npc_d     = npc_q;
        dr_d      = dr_q;
        sr1_d     = sr1_q;
        sr2_d     = sr2_q;
        wctl_d    = wctl_q;
        alu_op_d  = alu_op_q;
        imm_sel_d = imm_sel_q;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        wb_en_d   = wb_en_q;
        valid_d   = 1'b0;
        pending_d = eff;
        if (issue) begin
            ir_d      = instr_in;
            npc_d     = npc_in;
            dr_d      = f_dr;
            sr1_d     = f_sr1;
            sr2_d     = f_sr2;
            wctl_d    = f_wctl;
            alu_op_d  = f_alu_op;
            imm_sel_d = (is_add | is_and) & instr_in[5];
            mem_rd_d  = f_load;
            mem_wr_d  = f_store;
            wb_en_d   = f_wb;
            valid_d   = 1'b1;
            // Setting after the retire clear makes a same-register set win.
            if (f_wb) pending_d[f_dr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q      <= '0;
            npc_q     <= '0;
            dr_q      <= '0;
            sr1_q     <= '0;
            sr2_q     <= '0;
            wctl_q    <= '0;
            alu_op_q  <= '0;
            imm_sel_q <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            ir_q      <= ir_d;
            npc_q     <= npc_d;
            dr_q      <= dr_d;
            sr1_q     <= sr1_d;
            sr2_q     <= sr2_d;
            wctl_q    <= wctl_d;
            alu_op_q  <= alu_op_d;
            imm_sel_q <= imm_sel_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            wb_en_q   <= wb_en_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
        end
    end

    assign ir        = ir_q;
    assign npc_out   = npc_q;
    assign dr        = dr_q;
    assign sr1       = sr1_q;
    assign sr2       = sr2_q;
    assign W_Control = wctl_q;
    assign alu_op    = alu_op_q;
    assign imm_sel   = imm_sel_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign wb_en     = wb_en_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_lc3_decode.sv
// Bench for lc3_decode: directed scenarios plus randomized traffic against a
// mnemonic-level reference model with a per-register pending table.
module tb_lc3_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_decode;
    logic [15:0] instr_in, npc_in;
    logic        wb_valid;
    logic [2:0]  wb_dr;
    logic [15:0] ir, npc_out;
    logic [2:0]  dr, sr1, sr2, W_Control;
    logic [1:0]  alu_op;
    logic        imm_sel, mem_rd, mem_wr, wb_en, valid_out, stall;

    int checks = 0;
    int errors = 0;

    logic [50:0] e_out;
    bit   [7:0]  mpend;
    bit          last_stall;

    lc3_decode #(.NREG(8)) dut (
        .clk(clk), .rst(rst), .enable_decode(enable_decode), .instr_in(instr_in),
        .npc_in(npc_in), .wb_valid(wb_valid), .wb_dr(wb_dr), .ir(ir), .npc_out(npc_out),
        .dr(dr), .sr1(sr1), .sr2(sr2), .W_Control(W_Control), .alu_op(alu_op),
        .imm_sel(imm_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_en(wb_en),
        .valid_out(valid_out), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic string mnem(input logic [15:0] i);
        case (i[15:12])
            4'd0:  return "BR";
            4'd1:  return "ADD";
            4'd2:  return "LD";
            4'd3:  return "ST";
            4'd4:  return "JSR";
            4'd5:  return "AND";
            4'd6:  return "LDR";
            4'd7:  return "STR";
            4'd8:  return "RTI";
            4'd9:  return "NOT";
            4'd10: return "LDI";
            4'd11: return "STI";
            4'd12: return "JMP";
            4'd13: return "RES";
            4'd14: return "LEA";
            default: return "TRAP";
        endcase
    endfunction

    // Expected fields of a freshly issued instruction plus the set of registers it reads.
    function automatic void model(input logic [15:0] i, input logic [15:0] npc,
                                  output logic [50:0] fields, output bit [7:0] srcs,
                                  output bit writes);
        string m;
        bit    load, store, logic_op;
        logic [2:0] wc, s2;
        logic [1:0] aop;
        m        = mnem(i);
        load     = (m == "LD") || (m == "LDR") || (m == "LDI");
        store    = (m == "ST") || (m == "STR") || (m == "STI");
        logic_op = (m == "ADD") || (m == "AND");
        writes   = logic_op || (m == "NOT") || load || (m == "LEA");
        wc  = load ? 3'd1 : (m == "LEA") ? 3'd2 : 3'd0;
        aop = (m == "ADD") ? 2'd0 : (m == "AND") ? 2'd1 : (m == "NOT") ? 2'd2 : 2'd3;
        s2  = store ? i[11:9] : i[2:0];
        srcs = '0;
        if (logic_op || m == "NOT" || m == "LDR" || m == "JMP" || m == "STR") srcs[i[8:6]] = 1'b1;
        if (logic_op && !i[5]) srcs[i[2:0]] = 1'b1;
        if (store) srcs[i[11:9]] = 1'b1;
        fields = {i, npc, i[11:9], i[8:6], s2, wc, aop, logic_op & i[5], load, store, writes, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with inputs already driven; advances one cycle.
    task automatic cycle();
        bit [7:0]    eff, srcs;
        bit          writes, hz;
        logic [50:0] f;
        #1;
        eff = mpend;
        if (wb_valid) eff[wb_dr] = 1'b0;
        model(instr_in, npc_in, f, srcs, writes);
        hz = ((srcs & eff) != 8'h00) || (writes && eff[instr_in[11:9]]);
        check("stall", {63'd0, stall}, {63'd0, enable_decode && hz});
        last_stall = enable_decode && hz;
        @(posedge clk);
        if (enable_decode && !hz) begin
            e_out = f;
            if (writes) eff[instr_in[11:9]] = 1'b1;
        end else begin
            e_out[0] = 1'b0;
        end
        mpend = eff;
        #1;
        check("outputs", {13'd0, ir, npc_out, dr, sr1, sr2, W_Control, alu_op, imm_sel,
                          mem_rd, mem_wr, wb_en, valid_out}, {13'd0, e_out});
        check("pending", {56'd0, dut.pending_q}, {56'd0, mpend});
    endtask

    task automatic drive(input bit en, input logic [15:0] i, input bit wv, input logic [2:0] wd);
        enable_decode = en;
        instr_in      = i;
        npc_in        = 16'($urandom);
        wb_valid      = wv;
        wb_dr         = wd;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 3'd0);
        e_out = '0;
        mpend = '0;
        last_stall = 1'b0;
        #2;
        check("reset_outputs", {13'd0, ir, npc_out, dr, sr1, sr2, W_Control, alu_op, imm_sel,
                                mem_rd, mem_wr, wb_en, valid_out}, 64'd0);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill the scoreboard with LEA to every register, then stall on an ADD.
        for (int r = 0; r < 8; r++) begin
            drive(1'b1, 16'hE000 | 16'(r << 9), 1'b0, 3'd0);
            cycle();
        end
        check("filled", {56'd0, dut.pending_q}, 64'hFF);
        drive(1'b1, 16'h1642, 1'b0, 3'd0);
        cycle();
        check("stalled", {63'd0, stall}, 64'd1);

        // Asynchronous reset in the middle of a cycle while stalled.
        #2 rst = 1'b0;
        #1;
        e_out = '0;
        mpend = '0;
        check("async_outputs", {13'd0, ir, npc_out, dr, sr1, sr2, W_Control, alu_op, imm_sel,
                                mem_rd, mem_wr, wb_en, valid_out}, 64'd0);
        check("async_pending", {56'd0, dut.pending_q}, 64'd0);
        enable_decode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_valid", {63'd0, valid_out}, 64'd0);

        // ADD R3,R1,R2
        drive(1'b1, 16'h1642, 1'b0, 3'd0);
        cycle();
        check("add_fields", {52'd0, valid_out, dr, sr1, sr2, W_Control, alu_op, imm_sel, wb_en},
              {52'd0, 1'b1, 3'd3, 3'd1, 3'd2, 3'd0, 2'b00, 1'b0, 1'b1});
        check("add_pending", {56'd0, dut.pending_q}, 64'h08);

        // AND R4,R3,#1 stalls until R3 retires, then issues through the bypass.
        drive(1'b1, 16'h58E1, 1'b0, 3'd0);
        cycle();
        cycle();
        check("and_held", {62'd0, stall, valid_out}, {62'd0, 1'b1, 1'b0});
        wb_valid = 1'b1;
        wb_dr    = 3'd3;
        cycle();
        check("and_issue", {56'd0, dut.pending_q}, 64'h10);
        check("and_valid", {63'd0, valid_out}, 64'd1);

        // LD R5 then LEA R6.
        drive(1'b1, 16'h2A05, 1'b0, 3'd0);
        cycle();
        check("ld_fields", {59'd0, W_Control, mem_rd, wb_en}, {59'd0, 3'd1, 1'b1, 1'b1});
        drive(1'b1, 16'hEC03, 1'b0, 3'd0);
        cycle();
        check("lea_wctl", {61'd0, W_Control}, 64'd2);
        check("lea_pending", {56'd0, dut.pending_q}, 64'h70);

        // STR R5,R2,#0 waits on R5.
        drive(1'b1, 16'h7A80, 1'b0, 3'd0);
        cycle();
        wb_valid = 1'b1;
        wb_dr    = 3'd5;
        cycle();
        check("str_fields", {58'd0, sr2, mem_wr, wb_en, valid_out}, {58'd0, 3'd5, 1'b1, 1'b0, 1'b1});
        check("str_pending", {56'd0, dut.pending_q}, 64'h50);

        // ADD R3,R3,#0 issued in the same cycle R3 retires: the new write stays pending.
        drive(1'b1, 16'h1642, 1'b0, 3'd0);
        cycle();
        drive(1'b1, 16'h16E0, 1'b1, 3'd3);
        cycle();
        check("bypass_valid", {63'd0, valid_out}, 64'd1);
        check("set_wins", {63'd0, dut.pending_q[3]}, 64'd1);

        // Randomized traffic; a stalled instruction is held as fetch would.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] ni;
            bit          wv;
            logic [2:0]  wd;
            int          start;
            ni = last_stall ? instr_in : 16'($urandom);
            wv = 1'b0;
            wd = 3'($urandom_range(0, 7));
            if (mpend != 8'h00 && $urandom_range(0, 2) != 0) begin
                start = $urandom_range(0, 7);
                for (int k = 0; k < 8; k++) begin
                    if (!wv && mpend[(start + k) % 8]) begin
                        wv = 1'b1;
                        wd = 3'((start + k) % 8);
                    end
                end
            end else if ($urandom_range(0, 7) == 0) begin
                wv = 1'b1;
            end
            drive(last_stall || ($urandom_range(0, 3) != 0), ni, wv, wd);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_decode.md
Name: lc3_decode

Overview:
- Decode stage of the LC3 pipeline; the producing end of the writeback/register-file interface.
- Registers each accepted instruction and produces the fields consumed downstream: dr, sr1, sr2, W_Control and the writeback enable.
- Keeps an 8-entry pending-write scoreboard. An entry is set when a register-writing instruction issues and cleared when writeback retires it.
- Stalls issue on RAW or WAW hazards against in-flight writes.

Parameters:
- NREG, 8, number of architectural registers (scoreboard width; dr/sr fields are 3 bits).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- enable_decode  input  1  instruction present on instr_in this cycle.
- instr_in  input  16  instruction word from fetch.
- npc_in  input  16  PC+1 of instr_in.
- wb_valid  input  1  writeback is retiring a register write this cycle.
- wb_dr  input  3  destination register being retired.
- ir  output  16  registered instruction.
- npc_out  output  16  registered npc.
- dr  output  3  destination register, IR[11:9].
- sr1  output  3  source 1, IR[8:6].
- sr2  output  3  source 2: IR[2:0], or IR[11:9] for ST/STR/STI.
- W_Control  output  3  writeback select: 0 aluout, 1 memout, 2 pcout.
- alu_op  output  2  00 ADD, 01 AND, 10 NOT, 11 none.
- imm_sel  output  1  IR[5] for ADD/AND; 0 otherwise.
- mem_rd  output  1  LD/LDR/LDI.
- mem_wr  output  1  ST/STR/STI.
- wb_en  output  1  instruction writes dr.
- valid_out  output  1  registered outputs hold a newly issued instruction.
- stall  output  1  combinational; instruction on instr_in not accepted this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registered outputs go to 0; pending[7:0] goes to 0.
  - Held until the first rising clk edge after rst=1.
  - Reset mid-stall discards the stalled instruction and the whole scoreboard.
- Opcode classes, by IR[15:12]:
  - ALU: ADD 0001, AND 0101, NOT 1001. W_Control=0, wb_en=1.
  - LOAD: LD 0010, LDR 0110, LDI 1010. W_Control=1, wb_en=1, mem_rd=1.
  - LEA: 1110. W_Control=2, wb_en=1.
  - STORE: ST 0011, STR 0111, STI 1011. mem_wr=1, wb_en=0.
  - BR 0000, JMP 1100. wb_en=0.
  - All other opcodes: NOP class. wb_en=0, alu_op=11, no sources.
  - When wb_en=0, W_Control=0.
- Sources used for hazard checks:
  - ADD/AND: sr1; sr2 only when IR[5]=0.
  - NOT, LDR, JMP: sr1.
  - STR: sr1 and IR[11:9].
  - ST/STI: IR[11:9].
  - LD, LDI, LEA, BR: none.
- Effective pending: eff = pending with bit wb_dr cleared when wb_valid=1. This is same-cycle retire bypass.
- hazard: any used source has its eff bit set, OR (wb_en class AND eff[IR[11:9]]) for WAW.
- stall = enable_decode & hazard.
- Issue condition: enable_decode=1 and stall=0. At that clock edge:
  - All output fields load from instr_in/npc_in.
  - valid_out=1 for exactly one cycle.
  - Latency from instr_in to outputs is one cycle.
- Otherwise valid_out=0 next cycle and the other registered outputs hold their values.
- Fetch must hold instr_in stable while stall=1.
- Scoreboard update each edge: pending_next = eff, then bit dr is set if issuing with wb_en=1.
  - Set wins over a same-cycle clear of the same register.
- wb_valid for a non-pending register is harmless; the bit stays 0.
- No overflow is possible: at most one pending write per register, guaranteed by the WAW stall.

Test Plan:
- Reset with pending=0xFF, then rst=0 asynchronously mid-cycle -> all outputs 0 immediately; pending=0x00; after release, valid_out=0.
- Issue 0x1642 (ADD R3,R1,R2) -> next cycle valid_out=1, dr=3, sr1=1, sr2=2, W_Control=0, alu_op=00, imm_sel=0, wb_en=1; pending=0x08.
- With pending[3]=1, present 0x58E1 (AND R4,R3,#1) -> stall=1 and valid_out=0 each cycle.
  - Pulse wb_valid=1, wb_dr=3 in the same cycle -> stall=0, instruction issues, pending=0x10.
- Issue 0x2A05 (LD R5) -> W_Control=1, mem_rd=1. Then 0xEC03 (LEA R6) -> W_Control=2; pending has bits 5 and 6 set.
- With pending[5]=1, present 0x7A80 (STR R5,R2,#0) -> stall=1.
  - After wb_dr=5 retires -> issue with sr2=5, mem_wr=1, wb_en=0; pending unchanged by the issue.
- With pending[3]=1, present 0x16E0 (ADD R3,R3,#0) together with wb_valid=1, wb_dr=3 -> issues (bypass); pending[3] remains 1 (set wins).
